// File: rtl/oled_fb_pkg.sv
// Shared constants and types for the OLED framebuffer: opcodes, parser states, pixel width.
package oled_fb_pkg;

  localparam int unsigned PIX_W = 16;

  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_SETCOL = 8'h02;
  localparam logic [7:0] OP_WRITE  = 8'h03;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_CMD,
    S_COL_ARG,
    S_CNT_ARG,
    S_DATA_LO,
    S_DATA_HI
  } fb_state_t;

endpackage

// File: rtl/oled_fb_ram.sv
// 256 x 16 simple dual-port RAM: one write port, one registered read port (read-before-write).
module oled_fb_ram
  import oled_fb_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [7:0]       i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic [7:0]       i_raddr,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] r_mem [256];
  logic [PIX_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/oled_framebuffer.sv
// Column bitmap store for the OLED driver: byte-stream command parser plus forced-zero read path.
module oled_framebuffer
  import oled_fb_pkg::*;
#(
  parameter int unsigned COLS = 80
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       row,
  output logic [PIX_W-1:0] pixels,
  output logic             busy
);

  fb_state_t        r_state;
  logic [7:0]       r_clr_idx;
  logic [7:0]       r_wp;
  logic [8:0]       r_cnt;
  logic [7:0]       r_lo;
  logic             r_busy;
  logic             r_rx_ready;
  logic             r_zero;

  logic             w_fire;
  logic             w_clr_last;
  logic             w_clr_next;
  logic             w_row_oob;
  logic             w_we;
  logic [7:0]       w_waddr;
  logic [PIX_W-1:0] w_wdata;
  logic [PIX_W-1:0] w_rdata;
  logic [7:0]       w_wp_inc;

  assign w_fire     = rx_valid && r_rx_ready;
  assign w_clr_last = (r_clr_idx == 8'(COLS - 1));
  assign w_clr_next = ((r_state == S_CLEAR) && !w_clr_last) ||
                      ((r_state == S_CMD) && w_fire && (rx_data == OP_CLEAR));
  assign w_row_oob  = ({1'b0, row} >= 9'(COLS));
  assign w_wp_inc   = (r_wp == 8'(COLS - 1)) ? 8'd0 : r_wp + 8'd1;

  // The sweep owns the write port; otherwise a word commits on the high-byte handshake.
  assign w_we    = (r_state == S_CLEAR) || ((r_state == S_DATA_HI) && w_fire);
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_idx : r_wp;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : {rx_data, r_lo};

  oled_fb_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (row),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_idx  <= 8'd0;
      r_wp       <= 8'd0;
      r_cnt      <= 9'd0;
      r_lo       <= 8'd0;
      r_busy     <= 1'b1;
      r_rx_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 8'd1;
          if (w_clr_last) begin
            r_state    <= S_CMD;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
          end
        end
        S_CMD: begin
          if (w_fire) begin
            case (rx_data)
              OP_CLEAR: begin
                r_state    <= S_CLEAR;
                r_clr_idx  <= 8'd0;
                r_busy     <= 1'b1;
                r_rx_ready <= 1'b0;
              end
              OP_SETCOL: r_state <= S_COL_ARG;
              OP_WRITE:  r_state <= S_CNT_ARG;
              default:   r_state <= S_CMD;
            endcase
          end
        end
        S_COL_ARG: begin
          if (w_fire) begin
            r_wp    <= ({1'b0, rx_data} < 9'(COLS)) ? rx_data : 8'd0;
            r_state <= S_CMD;
          end
        end
        S_CNT_ARG: begin
          if (w_fire) begin
            r_cnt   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            r_state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_fire) begin
            r_lo    <= rx_data;
            r_state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_fire) begin
            r_wp    <= w_wp_inc;
            r_cnt   <= r_cnt - 9'd1;
            r_state <= (r_cnt == 9'd1) ? S_CMD : S_DATA_LO;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Zero covers the cycle entering a sweep and the cycle leaving it, so stale RAM never shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= w_row_oob || r_busy || w_clr_next;
    end
  end

  assign pixels   = r_zero ? '0 : w_rdata;
  assign busy     = r_busy;
  assign rx_ready = r_rx_ready;

endmodule

// File: tb/tb_oled_framebuffer.sv
// Directed bench for oled_framebuffer: sweep timing, SETCOL/WRITE, wrap, read-before-write, clear, reset abort.
module tb_oled_framebuffer;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  row;
  logic [15:0] pixels;
  logic        busy;

  int total = 0;
  int bad   = 0;

  oled_framebuffer #(.COLS(80)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .row      (row),
    .pixels   (pixels),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 16'(rx_ready), 16'h0001);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic read_row(input logic [7:0] r, input logic [15:0] exp, input string tag);
    @(negedge clk);
    row = r;
    @(posedge clk);
    #1;
    check(tag, pixels, exp);
  endtask

  // Called at a negedge while busy is high; counts busy cycles until it drops.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(tag, 16'(n), 16'd80);
    check({tag, "_ready"}, 16'(rx_ready), 16'h0001);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    row      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   16'(busy), 16'h0001);
    check("rst_ready",  16'(rx_ready), 16'h0000);
    check("rst_pixels", pixels, 16'h0000);

    @(negedge clk);
    reset_n = 1'b1;
    wait_clear("por_sweep");
    for (int r = 0; r < 80; r++) read_row(8'(r), 16'h0000, "por_row");

    send(8'h02); send(8'h05); send(8'h03); send(8'h02);
    send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
    read_row(8'd5, 16'h1234, "w_row5");
    read_row(8'd6, 16'hABCD, "w_row6");
    read_row(8'd7, 16'h0000, "w_row7_untouched");
    send(8'h03); send(8'h01); send(8'h77); send(8'h77);
    read_row(8'd7, 16'h7777, "wp_at_7");

    send(8'h02); send(8'h4F); send(8'h03); send(8'h02);
    send(8'h11); send(8'h11); send(8'h22); send(8'h22);
    read_row(8'd79, 16'h1111, "wrap_row79");
    read_row(8'd0,  16'h2222, "wrap_row0");
    send(8'h02); send(8'hC8); send(8'h03); send(8'h01);
    send(8'h55); send(8'h55);
    read_row(8'd0, 16'h5555, "setcol_oob_to0");
    read_row(8'd85, 16'h0000, "row_oob_zero");

    @(negedge clk);
    row = 8'd3;
    send(8'h02); send(8'h03); send(8'h03); send(8'h01);
    send(8'hEF); send(8'hBE);
    check("rbw_old", pixels, 16'h0000);
    @(posedge clk);
    #1;
    check("rbw_new", pixels, 16'hBEEF);

    @(negedge clk);
    row = 8'd5;
    send(8'h01);
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      check("clr_pixels", pixels, 16'h0000);
      check("clr_ready",  16'(rx_ready), 16'h0000);
      n++;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("clr_cycles", 16'(n), 16'd80);
    check("clr_ready_after", 16'(rx_ready), 16'h0001);
    for (int r = 0; r < 80; r++) read_row(8'(r), 16'h0000, "clr_row");
    send(8'h02); send(8'h0A); send(8'h03); send(8'h01);
    send(8'hAA); send(8'hAA);
    read_row(8'd10, 16'hAAAA, "held_byte_not_taken");

    send(8'h02); send(8'h14); send(8'h03); send(8'h02); send(8'h34);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'h0001);
    reset_n = 1'b1;
    wait_clear("abort_sweep");
    read_row(8'd20, 16'h0000, "abort_row20");
    read_row(8'd0,  16'h0000, "abort_row0");
    send(8'h7F);
    send(8'h02); send(8'h15); send(8'h03); send(8'h01);
    send(8'hCD); send(8'hAB);
    read_row(8'd21, 16'hABCD, "junk_op_ignored");
    read_row(8'd20, 16'h0000, "abort_row20_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
